// File: rtl/fp_addsub_pipe.sv
// Pipelined floating-point add/subtract: input capture, align, add, normalise/pack.
// Truncating rounding, denormals flushed to zero, tag and status flags travel with the data.
module fp_addsub_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   new_instr,
  input  logic                   op_sub,
  input  logic [EXP_W+MAN_W:0]   opA,
  input  logic [EXP_W+MAN_W:0]   opB,
  input  logic [TAG_W-1:0]       dest_in,
  input  logic                   stall,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   write_enable,
  output logic [TAG_W-1:0]       reg_dest,
  output logic                   flag_ovf,
  output logic                   flag_unf,
  output logic                   flag_inv
);

  localparam int unsigned W  = EXP_W + MAN_W + 1;
  localparam int unsigned LW = $clog2(MAN_W + 2);
  localparam int unsigned XW = EXP_W + LW + 2;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  // ---------------- input capture ----------------
  logic             in_valid_q, in_sub_q;
  logic [W-1:0]     in_a_q, in_b_q;
  logic [TAG_W-1:0] in_tag_q;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      in_valid_q <= 1'b0;
      in_sub_q   <= 1'b0;
      in_a_q     <= '0;
      in_b_q     <= '0;
      in_tag_q   <= '0;
    end else if (!stall) begin
      in_valid_q <= new_instr;
      in_sub_q   <= op_sub;
      in_a_q     <= opA;
      in_b_q     <= opB;
      in_tag_q   <= dest_in;
    end
  end

  // ---------------- stage 1: classify, swap, align ----------------
  logic             a_sign, b_sign;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_man, b_man;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_ge_b;
  logic [MAN_W:0]   a_full, b_full;

  assign a_sign = in_a_q[W-1];
  assign b_sign = in_b_q[W-1] ^ in_sub_q;  // effective sign of B
  assign a_exp  = in_a_q[W-2:MAN_W];
  assign b_exp  = in_b_q[W-2:MAN_W];
  assign a_man  = in_a_q[MAN_W-1:0];
  assign b_man  = in_b_q[MAN_W-1:0];
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_inf  = (a_exp == EXP_ONES) && (a_man == '0);
  assign b_inf  = (b_exp == EXP_ONES) && (b_man == '0);
  assign a_nan  = (a_exp == EXP_ONES) && (a_man != '0);
  assign b_nan  = (b_exp == EXP_ONES) && (b_man != '0);
  assign a_ge_b = {a_exp, a_man} >= {b_exp, b_man};
  assign a_full = a_zero ? '0 : {1'b1, a_man};
  assign b_full = b_zero ? '0 : {1'b1, b_man};

  logic             s1_sign_d, s1_sub_d, s1_nan_d, s1_inf_d, s1_inf_sign_d;
  logic [EXP_W-1:0] s1_exp_d, exp_small;
  logic [MAN_W:0]   s1_man_l_d, s1_man_s_d, man_small;

  always_comb begin
    s1_sign_d     = a_ge_b ? a_sign : b_sign;
    s1_sub_d      = a_sign ^ b_sign;
    s1_exp_d      = a_ge_b ? a_exp : b_exp;
    exp_small     = a_ge_b ? b_exp : a_exp;
    s1_man_l_d    = a_ge_b ? a_full : b_full;
    man_small     = a_ge_b ? b_full : a_full;
    // Shifts of MAN_W+1 or more empty the (MAN_W+1)-bit mantissa on their own.
    s1_man_s_d    = man_small >> (s1_exp_d - exp_small);
    s1_nan_d      = a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign));
    s1_inf_d      = a_inf || b_inf;
    s1_inf_sign_d = a_inf ? a_sign : b_sign;
  end

  logic             s1_valid_q, s1_sign_q, s1_sub_q, s1_nan_q, s1_inf_q, s1_inf_sign_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [MAN_W:0]   s1_man_l_q, s1_man_s_q;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      s1_valid_q    <= 1'b0;
      s1_tag_q      <= '0;
      s1_sign_q     <= 1'b0;
      s1_sub_q      <= 1'b0;
      s1_exp_q      <= '0;
      s1_man_l_q    <= '0;
      s1_man_s_q    <= '0;
      s1_nan_q      <= 1'b0;
      s1_inf_q      <= 1'b0;
      s1_inf_sign_q <= 1'b0;
    end else if (!stall) begin
      s1_valid_q    <= in_valid_q;
      s1_tag_q      <= in_tag_q;
      s1_sign_q     <= s1_sign_d;
      s1_sub_q      <= s1_sub_d;
      s1_exp_q      <= s1_exp_d;
      s1_man_l_q    <= s1_man_l_d;
      s1_man_s_q    <= s1_man_s_d;
      s1_nan_q      <= s1_nan_d;
      s1_inf_q      <= s1_inf_d;
      s1_inf_sign_q <= s1_inf_sign_d;
    end
  end

  // ---------------- stage 2: add / subtract magnitudes ----------------
  logic [MAN_W+1:0] s2_sum_d;

  assign s2_sum_d = s1_sub_q ? ({1'b0, s1_man_l_q} - {1'b0, s1_man_s_q})
                             : ({1'b0, s1_man_l_q} + {1'b0, s1_man_s_q});

  logic             s2_valid_q, s2_sign_q, s2_nan_q, s2_inf_q, s2_inf_sign_q;
  logic [TAG_W-1:0] s2_tag_q;
  logic [EXP_W-1:0] s2_exp_q;
  logic [MAN_W+1:0] s2_sum_q;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      s2_valid_q    <= 1'b0;
      s2_tag_q      <= '0;
      s2_sign_q     <= 1'b0;
      s2_exp_q      <= '0;
      s2_sum_q      <= '0;
      s2_nan_q      <= 1'b0;
      s2_inf_q      <= 1'b0;
      s2_inf_sign_q <= 1'b0;
    end else if (!stall) begin
      s2_valid_q    <= s1_valid_q;
      s2_tag_q      <= s1_tag_q;
      s2_sign_q     <= s1_sign_q;
      s2_exp_q      <= s1_exp_q;
      s2_sum_q      <= s2_sum_d;
      s2_nan_q      <= s1_nan_q;
      s2_inf_q      <= s1_inf_q;
      s2_inf_sign_q <= s1_inf_sign_q;
    end
  end

  // ---------------- stage 3: normalise, special cases, pack ----------------
  logic [LW-1:0]    lzc;
  logic [XW-1:0]    exp_ext, norm_exp;  // two's complement, MSB set means negative
  logic [MAN_W-1:0] norm_man;
  logic             exp_neg, exp_le0, exp_ovf;
  logic [W-1:0]     res_d;
  logic             ovf_d, unf_d, inv_d;

  always_comb begin
    lzc = '0;
    for (int i = 0; i <= int'(MAN_W); i++) begin
      if (s2_sum_q[i]) lzc = LW'(int'(MAN_W) - i);
    end
  end

  always_comb begin
    exp_ext = XW'(s2_exp_q);
    if (s2_sum_q[MAN_W+1]) begin
      norm_exp = exp_ext + XW'(1);
      norm_man = s2_sum_q[MAN_W:1];
    end else begin
      norm_exp = exp_ext - XW'(lzc);
      // The leading one shifts out of the top, leaving only the stored fraction.
      norm_man = s2_sum_q[MAN_W-1:0] << lzc;
    end
    exp_neg = norm_exp[XW-1];
    exp_le0 = exp_neg || (norm_exp == '0);
    exp_ovf = !exp_neg && (norm_exp >= XW'(EXP_ONES));
  end

  always_comb begin
    res_d = {s2_sign_q, norm_exp[EXP_W-1:0], norm_man};
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inv_d = 1'b0;
    if (s2_nan_q) begin
      res_d = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
      inv_d = 1'b1;
    end else if (s2_inf_q) begin
      res_d = {s2_inf_sign_q, EXP_ONES, {MAN_W{1'b0}}};
    end else if (s2_sum_q == '0) begin
      res_d = '0;
    end else if (exp_ovf) begin
      res_d = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
      ovf_d = 1'b1;
    end else if (exp_le0) begin
      res_d = '0;
      unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      result       <= '0;
      write_enable <= 1'b0;
      reg_dest     <= '0;
      flag_ovf     <= 1'b0;
      flag_unf     <= 1'b0;
      flag_inv     <= 1'b0;
    end else if (!stall) begin
      write_enable <= s2_valid_q;
      flag_ovf     <= s2_valid_q & ovf_d;
      flag_unf     <= s2_valid_q & unf_d;
      flag_inv     <= s2_valid_q & inv_d;
      if (s2_valid_q) begin
        result   <= res_d;
        reg_dest <= s2_tag_q;
      end
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: single precision instance plus a half precision instance.
module tb_fp_addsub_pipe;

  logic        tb_clk = 1'b0;
  logic        nreset, new_instr, op_sub, stall;
  logic [31:0] op_a, op_b, result;
  logic [15:0] op_a_h, op_b_h, result_h;
  logic [3:0]  dest_in, reg_dest, reg_dest_h;
  logic        write_enable, flag_ovf, flag_unf, flag_inv;
  logic        write_enable_h, flag_ovf_h, flag_unf_h, flag_inv_h;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 tb_clk = ~tb_clk;

  fp_addsub_pipe u_dut (
    .clk          (tb_clk),
    .nreset       (nreset),
    .new_instr    (new_instr),
    .op_sub       (op_sub),
    .opA          (op_a),
    .opB          (op_b),
    .dest_in      (dest_in),
    .stall        (stall),
    .result       (result),
    .write_enable (write_enable),
    .reg_dest     (reg_dest),
    .flag_ovf     (flag_ovf),
    .flag_unf     (flag_unf),
    .flag_inv     (flag_inv)
  );

  fp_addsub_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) u_dut_h (
    .clk          (tb_clk),
    .nreset       (nreset),
    .new_instr    (new_instr),
    .op_sub       (op_sub),
    .opA          (op_a_h),
    .opB          (op_b_h),
    .dest_in      (dest_in),
    .stall        (stall),
    .result       (result_h),
    .write_enable (write_enable_h),
    .reg_dest     (reg_dest_h),
    .flag_ovf     (flag_ovf_h),
    .flag_unf     (flag_unf_h),
    .flag_inv     (flag_inv_h)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One isolated operation; flags are {ovf, unf, inv}.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [3:0] dst, input logic [31:0] exp_res,
                        input logic [2:0] exp_flags, input logic [15:0] ha,
                        input logic [15:0] hb, input logic [15:0] exp_h);
    @(negedge tb_clk);
    op_a = a; op_b = b; op_sub = sub; dest_in = dst; op_a_h = ha; op_b_h = hb;
    new_instr = 1'b1;
    @(negedge tb_clk);
    new_instr = 1'b0;
    repeat (2) @(posedge tb_clk);
    #1 check_eq({tag, "_early_we"}, write_enable, 0);
    @(posedge tb_clk);
    #1;
    check_eq({tag, "_we"}, write_enable, 1);
    check_eq({tag, "_res"}, result, exp_res);
    check_eq({tag, "_dest"}, reg_dest, dst);
    check_eq({tag, "_flags"}, {flag_ovf, flag_unf, flag_inv}, exp_flags);
    check_eq({tag, "_half"}, result_h, exp_h);
    @(posedge tb_clk);
    #1 check_eq({tag, "_we_drop"}, write_enable, 0);
  endtask

  // Commit monitor for the streaming phase: a commit is write_enable && !stall.
  logic [31:0] exp_q[$];
  logic [3:0]  tag_q[$];
  bit          mon_en = 1'b0;
  int          commits = 0;

  always @(negedge tb_clk) begin
    #1;
    if (mon_en && write_enable && !stall) begin
      commits++;
      if (exp_q.size() > 0) begin
        check_eq("pipe_res", result, exp_q.pop_front());
        check_eq("pipe_tag", reg_dest, tag_q.pop_front());
      end
    end
  end

  logic [31:0] pa [5] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F800000, 32'h3F000000};
  logic [31:0] pb [5] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'h3E800000};
  logic        ps [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [31:0] pe [5] = '{32'h40000000, 32'h40400000, 32'h40000000, 32'hBF800000, 32'h3F400000};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int we_seen;
    nreset = 1'b0; new_instr = 1'b0; op_sub = 1'b0; stall = 1'b0;
    op_a = '0; op_b = '0; op_a_h = '0; op_b_h = '0; dest_in = '0;
    repeat (2) @(posedge tb_clk);
    #1;
    check_eq("rst_res", result, 0);
    check_eq("rst_we", write_enable, 0);
    check_eq("rst_dest", reg_dest, 0);
    check_eq("rst_flags", {flag_ovf, flag_unf, flag_inv}, 0);
    check_eq("rst_half", result_h, 0);
    @(negedge tb_clk);
    nreset = 1'b1;

    run_op("add1",   32'h3F800000, 32'h3F800000, 1'b0, 4'd3, 32'h40000000, 3'b000,
           16'h3C00, 16'h3C00, 16'h4000);
    run_op("mixed",  32'h40400000, 32'hBF800000, 1'b0, 4'd6, 32'h40000000, 3'b000,
           16'h0, 16'h0, 16'h0);
    run_op("cancel", 32'h3FC00000, 32'h3FC00000, 1'b1, 4'd7, 32'h00000000, 3'b000,
           16'h0, 16'h0, 16'h0);
    run_op("ovf",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 4'd8, 32'h7F800000, 3'b100,
           16'h0, 16'h0, 16'h0);
    run_op("nan",    32'h7FC00000, 32'h3F800000, 1'b0, 4'd9, 32'h7FC00000, 3'b001,
           16'h0, 16'h0, 16'h0);
    run_op("infinf", 32'h7F800000, 32'h7F800000, 1'b1, 4'd10, 32'h7FC00000, 3'b001,
           16'h0, 16'h0, 16'h0);
    run_op("unf",    32'h00800001, 32'h00800000, 1'b1, 4'd11, 32'h00000000, 3'b010,
           16'h0, 16'h0, 16'h0);
    run_op("inf",    32'h3F800000, 32'h7F800000, 1'b1, 4'd12, 32'hFF800000, 3'b000,
           16'h0, 16'h0, 16'h0);

    // Back-to-back stream with a two-cycle stall while op 3 is being requested.
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge tb_clk);
      op_a = pa[i]; op_b = pb[i]; op_sub = ps[i]; dest_in = 4'(i + 1); new_instr = 1'b1;
      exp_q.push_back(pe[i]);
      tag_q.push_back(4'(i + 1));
      if (i == 2) begin
        stall = 1'b1;
        @(negedge tb_clk);
        @(negedge tb_clk);
        stall = 1'b0;
      end
    end
    @(negedge tb_clk);
    new_instr = 1'b0;
    repeat (8) @(negedge tb_clk);
    #2;
    mon_en = 1'b0;
    check_eq("pipe_commits", commits, 5);
    check_eq("pipe_left", exp_q.size(), 0);

    // Reset with two ops in flight, stall asserted at the same time.
    @(negedge tb_clk);
    op_a = 32'h3F800000; op_b = 32'h3F800000; op_sub = 1'b0; dest_in = 4'd9; new_instr = 1'b1;
    @(negedge tb_clk);
    dest_in = 4'd10;
    @(negedge tb_clk);
    new_instr = 1'b0; nreset = 1'b0; stall = 1'b1;
    @(posedge tb_clk);
    #1;
    check_eq("mid_rst_res", result, 0);
    check_eq("mid_rst_we", write_enable, 0);
    check_eq("mid_rst_dest", reg_dest, 0);
    check_eq("mid_rst_flags", {flag_ovf, flag_unf, flag_inv}, 0);
    @(negedge tb_clk);
    nreset = 1'b1; stall = 1'b0;
    we_seen = 0;
    repeat (6) begin
      @(posedge tb_clk);
      #1;
      if (write_enable) we_seen++;
    end
    check_eq("mid_rst_no_we", we_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
